cpu_mem_bridge: RTL and testbench

//  Registered bridge between a RISC-V core native memory port (valid/ready, wstrb) and the system bus
//  (one-cycle address strobe, write pulse, byte enables, read data after a fixed latency).

---
 rtl/cpu_mem_bridge.sv | 182 ++++++++++++++++++
 tb/tb_cpu_mem_bridge.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_bridge.sv
// cpu_mem_bridge: registered bridge from a RISC-V native memory port (valid/ready, wstrb)
// to the system bus (one-cycle address strobe, write pulse, byte enables, fixed-latency
// read data), with halt stalling, abort handling and an N-channel IRQ edge-to-pulse front end.
module cpu_mem_bridge #(
    parameter int address_width = 32,
    parameter int ReadLatency   = 1,
    parameter int IrqCount      = 1,
    parameter int IrqSyncStages = 2,
    parameter bit EnableCPUIRQ  = 1'b0
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     mem_valid_i,
    input  logic [address_width-1:0] mem_addr_i,
    input  logic [31:0]              mem_wdata_i,
    input  logic [3:0]               mem_wstrb_i,
    output logic [31:0]              mem_rdata_o,
    output logic                     mem_ready_o,
    input  logic                     cpu_halt_i,
    output logic [address_width-1:0] address_o,
    output logic [31:0]              data_o,
    output logic                     we_o,
    output logic [3:0]               we_ram_o,
    input  logic [31:0]              data_i,
    input  logic [IrqCount-1:0]      irq_i,
    output logic [IrqCount-1:0]      irq_o,
    output logic                     busy_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STROBE = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    // WAIT lasts ReadLatency cycles, so the counter starts one below the latency.
    localparam logic [3:0] CntLoad = 4'(ReadLatency - 1);

    state_t                   state_q, state_d;
    logic [address_width-1:0] addr_q, addr_d;
    logic [31:0]              wdata_q, wdata_d;
    logic [31:0]              rdata_q, rdata_d;
    logic [3:0]               wstrb_q, wstrb_d;
    logic [3:0]               cnt_q, cnt_d;
    logic                     abort_q, abort_d;

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic; an aborted request skips RESP so the core never sees a ready
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (mem_valid_i && !cpu_halt_i) state_d = S_STROBE;
            S_STROBE: state_d = S_WAIT;
            S_WAIT:   if (!cpu_halt_i && (cnt_q == 4'd0))
                          state_d = (abort_q || !mem_valid_i) ? S_IDLE : S_RESP;
            S_RESP:   if (!cpu_halt_i) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Request latch, latency counter, abort flag and read-data capture
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        abort_d = abort_q;
        case (state_q)
            S_IDLE: begin
                if (mem_valid_i && !cpu_halt_i) begin
                    addr_d  = mem_addr_i;
                    wdata_d = mem_wdata_i;
                    wstrb_d = mem_wstrb_i;
                    abort_d = 1'b0;
                end
            end
            S_STROBE: begin
                cnt_d = CntLoad;
                if (!mem_valid_i) abort_d = 1'b1;
            end
            S_WAIT: begin
                if (!mem_valid_i) abort_d = 1'b1;
                if (!cpu_halt_i) begin
                    if (cnt_q == 4'd0) rdata_d = data_i;
                    else               cnt_d   = cnt_q - 4'd1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; cleared on reset so every output starts at zero
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            abort_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            abort_q <= abort_d;
        end
    end

    // Bus and core outputs; address/enables only during the strobe, ready follows halt directly
    always_comb begin
        address_o   = '0;
        we_o        = 1'b0;
        we_ram_o    = 4'b0000;
        data_o      = wdata_q;
        mem_rdata_o = rdata_q;
        mem_ready_o = (state_q == S_RESP) && !cpu_halt_i;
        busy_o      = (state_q != S_IDLE);
        if (state_q == S_STROBE) begin
            address_o = addr_q;
            we_o      = (wstrb_q != 4'b0000);
            we_ram_o  = wstrb_q;
        end
    end

    logic [IrqCount-1:0] irq_cur;
    logic [IrqCount-1:0] irq_prev_q, irq_prev_d;
    logic [IrqCount-1:0] irq_pulse_q, irq_pulse_d;

    generate
        if (IrqSyncStages == 0) begin : g_nosync
            assign irq_cur = irq_i;
        end else begin : g_sync
            logic [IrqCount-1:0] sync_q [IrqSyncStages];
            logic [IrqCount-1:0] sync_d [IrqSyncStages];

            // Shift each asynchronous line through the synchroniser chain
            always_comb begin
                sync_d[0] = irq_i;
                for (int k = 1; k < IrqSyncStages; k++) sync_d[k] = sync_q[k-1];
            end

            // Synchroniser flops
            always_ff @(posedge clk_i) begin
                for (int k = 0; k < IrqSyncStages; k++) begin
                    if (reset_i) sync_q[k] <= '0;
                    else         sync_q[k] <= sync_d[k];
                end
            end

            assign irq_cur = sync_q[IrqSyncStages-1];
        end
    endgenerate

    // Rising-edge detect per channel; the front end is gated off when IRQs are disabled
    always_comb begin
        irq_prev_d  = irq_cur;
        irq_pulse_d = EnableCPUIRQ ? (irq_cur & ~irq_prev_q) : '0;
    end

    // Edge-detect history and registered pulse; zero at reset so a held line pulses once
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            irq_prev_q  <= '0;
            irq_pulse_q <= '0;
        end else begin
            irq_prev_q  <= irq_prev_d;
            irq_pulse_q <= irq_pulse_d;
        end
    end

    assign irq_o = irq_pulse_q;

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Testbench for cpu_mem_bridge: directed and randomized transactions and IRQ traffic,
// checked against a cycle-count reference model of the bridge behaviour.
module tb_cpu_mem_bridge;

    localparam int RL   = 4;
    localparam int NIRQ = 4;
    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        mem_valid_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [3:0]  mem_wstrb_i;
    logic [31:0] mem_rdata_o;
    logic        mem_ready_o;
    logic        cpu_halt_i;
    logic [31:0] address_o;
    logic [31:0] data_o;
    logic        we_o;
    logic [3:0]  we_ram_o;
    logic [31:0] data_i;
    logic [NIRQ-1:0] irq_i;
    logic [NIRQ-1:0] irq_o;
    logic        busy_o;

    int tests = 0;
    int fails = 0;
    logic [NIRQ-1:0] irq_hist[$];

    always #5 clk = ~clk;

    cpu_mem_bridge #(
        .address_width(32),
        .ReadLatency  (RL),
        .IrqCount     (NIRQ),
        .IrqSyncStages(SYNC),
        .EnableCPUIRQ (1'b1)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .mem_valid_i(mem_valid_i),
        .mem_addr_i (mem_addr_i),
        .mem_wdata_i(mem_wdata_i),
        .mem_wstrb_i(mem_wstrb_i),
        .mem_rdata_o(mem_rdata_o),
        .mem_ready_o(mem_ready_o),
        .cpu_halt_i (cpu_halt_i),
        .address_o  (address_o),
        .data_o     (data_o),
        .we_o       (we_o),
        .we_ram_o   (we_ram_o),
        .data_i     (data_i),
        .irq_i      (irq_i),
        .irq_o      (irq_o),
        .busy_o     (busy_o)
    );

    // One transaction starting in cycle 0 (request accepted). Expected timing derived from
    // the rules: data sampled in the RL-th unhalted WAIT cycle (WAIT starts at cycle 2),
    // ready in the first unhalted cycle after that. halt_mask bit c = halt in cycle c.
    task automatic do_txn(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input logic [63:0] halt_mask,
                          input int abort_at, input bit fixed, input logic [31:0] fdata,
                          output int ready_cyc);
        logic [31:0] dat [64];
        int  s, r, n, last;
        bit  aborted, exp_rdy, valid_now;
        s = -1; r = -1; n = 0;
        for (int c = 2; c < 64; c++) begin
            if (!halt_mask[c]) begin
                n++;
                if (n == RL) begin s = c; break; end
            end
        end
        for (int c = s + 1; c < 64; c++) begin
            if (!halt_mask[c]) begin r = c; break; end
        end
        aborted   = (abort_at > 0) && (abort_at <= s);
        last      = aborted ? s + 3 : r;
        ready_cyc = -1;
        for (int c = 0; c <= last; c++) begin
            @(posedge clk); #1;
            valid_now   = !(aborted && c >= abort_at);
            mem_valid_i = valid_now;
            if (valid_now) begin
                mem_addr_i  = addr;
                mem_wdata_i = wdata;
                mem_wstrb_i = wstrb;
            end else begin
                mem_addr_i  = $urandom;
                mem_wdata_i = $urandom;
                mem_wstrb_i = 4'($urandom);
            end
            cpu_halt_i = (c == 0) ? 1'b0 : halt_mask[c];
            dat[c]     = fixed ? fdata : $urandom;
            data_i     = dat[c];
            @(negedge clk);
            if (mem_ready_o === 1'b1 && ready_cyc < 0) ready_cyc = c;
            exp_rdy = !aborted && (c == r);
            tests++;
            if (mem_ready_o !== exp_rdy) begin
                fails++;
                $display("FAIL txn_ready cyc=%0d got=%b exp=%b", c, mem_ready_o, exp_rdy);
            end
            tests++;
            if (address_o !== ((c == 1) ? addr : 32'h0)) begin
                fails++;
                $display("FAIL txn_address cyc=%0d got=%h exp=%h", c, address_o, (c == 1) ? addr : 32'h0);
            end
            tests++;
            if (we_o !== ((c == 1) && (wstrb != 4'b0))) begin
                fails++;
                $display("FAIL txn_we cyc=%0d got=%b exp=%b", c, we_o, (c == 1) && (wstrb != 4'b0));
            end
            tests++;
            if (we_ram_o !== ((c == 1) ? wstrb : 4'b0)) begin
                fails++;
                $display("FAIL txn_we_ram cyc=%0d got=%b exp=%b", c, we_ram_o, (c == 1) ? wstrb : 4'b0);
            end
            if (c >= 1) begin
                tests++;
                if (data_o !== wdata) begin
                    fails++;
                    $display("FAIL txn_data_o cyc=%0d got=%h exp=%h", c, data_o, wdata);
                end
            end
            if (c == 0 || (c >= 1 && c <= s) || (!aborted && c <= r) || (aborted && c >= s + 2)) begin
                tests++;
                if (busy_o !== (c >= 1 && (aborted ? (c <= s) : (c <= r)))) begin
                    fails++;
                    $display("FAIL txn_busy cyc=%0d got=%b", c, busy_o);
                end
            end
            if (!aborted && c > s) begin
                tests++;
                if (mem_rdata_o !== dat[s]) begin
                    fails++;
                    $display("FAIL txn_rdata cyc=%0d got=%h exp=%h", c, mem_rdata_o, dat[s]);
                end
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            mem_valid_i = 1'b0;
            cpu_halt_i  = 1'($urandom);
            mem_addr_i  = $urandom;
            data_i      = $urandom;
            @(negedge clk);
            tests++;
            if (busy_o !== 1'b0 || mem_ready_o !== 1'b0 || address_o !== 32'h0) begin
                fails++;
                $display("FAIL idle busy=%b ready=%b addr=%h exp 0/0/0", busy_o, mem_ready_o, address_o);
            end
        end
        cpu_halt_i = 1'b0;
    endtask

    task automatic check_ready_cyc(input string name, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s ready_cycle got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // IRQ model: a level present in cycle m-3 and absent in cycle m-4 pulses in cycle m
    task automatic irq_clear();
        irq_hist.delete();
        repeat (4) irq_hist.push_back('0);
    endtask

    task automatic irq_step(input logic [NIRQ-1:0] v, input bit halt);
        int m;
        logic [NIRQ-1:0] exp;
        @(posedge clk); #1;
        irq_i      = v;
        cpu_halt_i = halt;
        irq_hist.push_back(v);
        @(negedge clk);
        m   = irq_hist.size() - 1;
        exp = irq_hist[m-3] & ~irq_hist[m-4];
        tests++;
        if (irq_o !== exp) begin
            fails++;
            $display("FAIL irq_model step=%0d got=%b exp=%b", m, irq_o, exp);
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        irq_i   = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        tests++;
        if (address_o !== 32'h0 || data_o !== 32'h0 || we_o !== 1'b0 || we_ram_o !== 4'h0 ||
            mem_rdata_o !== 32'h0 || mem_ready_o !== 1'b0 || busy_o !== 1'b0 || irq_o !== 4'h0) begin
            fails++;
            $display("FAIL reset_outputs addr=%h data=%h we=%b weram=%b rdata=%h rdy=%b busy=%b irq=%b exp all 0",
                     address_o, data_o, we_o, we_ram_o, mem_rdata_o, mem_ready_o, busy_o, irq_o);
        end
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            reset_i = 1'b0;
            @(negedge clk);
            tests++;
            if (irq_o !== ((c == 3) ? 4'b1111 : 4'b0000)) begin
                fails++;
                $display("FAIL reset_release_irq c=%0d got=%b exp=%b", c, irq_o, (c == 3) ? 4'b1111 : 4'b0000);
            end
        end
        irq_i = '0;
        idle_cycles(5);
    endtask

    task automatic test_read_basic();
        int rc;
        do_txn(32'h0000_0100, $urandom, 4'b0000, 64'h0, 0, 1'b1, 32'hCAFE_F00D, rc);
        check_ready_cyc("read_basic", rc, RL + 2);
        tests++;
        if (mem_rdata_o !== 32'hCAFE_F00D) begin
            fails++;
            $display("FAIL read_basic_data got=%h exp=cafef00d", mem_rdata_o);
        end
        idle_cycles(2);
    endtask

    task automatic test_write();
        int rc;
        do_txn(32'h0000_0200, 32'h1234_5678, 4'b0011, 64'h0, 0, 1'b0, 32'h0, rc);
        check_ready_cyc("write", rc, RL + 2);
        idle_cycles(2);
    endtask

    task automatic test_halt_wait();
        int rc;
        do_txn($urandom, $urandom, 4'b0000, 64'h38, 0, 1'b0, 32'h0, rc);
        check_ready_cyc("halt_wait", rc, RL + 2 + 3);
        idle_cycles(2);
    endtask

    task automatic test_halt_resp();
        int rc;
        do_txn($urandom, $urandom, 4'b0000, 64'h7 << (RL + 2), 0, 1'b0, 32'h0, rc);
        check_ready_cyc("halt_resp", rc, RL + 5);
        idle_cycles(1);
        do_txn($urandom, $urandom, 4'b1111, 64'h2, 0, 1'b0, 32'h0, rc);
        check_ready_cyc("halt_strobe", rc, RL + 2);
        idle_cycles(2);
    endtask

    task automatic test_abort();
        int rc;
        do_txn(32'h0000_0400, $urandom, 4'b0000, 64'h0, 2, 1'b0, 32'h0, rc);
        check_ready_cyc("abort", rc, -1);
        do_txn(32'h0000_0404, $urandom, 4'b0100, 64'h0, RL + 1, 1'b0, 32'h0, rc);
        check_ready_cyc("abort_late", rc, -1);
        do_txn(32'h0000_0408, $urandom, 4'b0000, 64'h0, 0, 1'b0, 32'h0, rc);
        check_ready_cyc("after_abort", rc, RL + 2);
        idle_cycles(2);
    endtask

    task automatic test_back_to_back();
        int rc;
        for (int i = 0; i < 4; i++) begin
            do_txn($urandom, $urandom, 4'($urandom), 64'h0, 0, 1'b0, 32'h0, rc);
            check_ready_cyc("back_to_back", rc, RL + 2);
        end
        idle_cycles(2);
    endtask

    task automatic test_reset_mid();
        int rc;
        @(posedge clk); #1;
        mem_valid_i = 1'b1; mem_addr_i = 32'h0000_0300; mem_wstrb_i = 4'b0000;
        mem_wdata_i = 32'hA5A5_5A5A; cpu_halt_i = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        tests++;
        if (address_o !== 32'h0000_0300) begin
            fails++;
            $display("FAIL reset_mid_strobe got=%h exp=00000300", address_o);
        end
        @(posedge clk); #1;
        reset_i = 1'b1;
        @(posedge clk); #1;
        reset_i = 1'b0; mem_valid_i = 1'b0;
        @(negedge clk);
        tests++;
        if (busy_o !== 1'b0 || data_o !== 32'h0 || mem_rdata_o !== 32'h0 || mem_ready_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid busy=%b data=%h rdata=%h rdy=%b exp all 0", busy_o, data_o, mem_rdata_o, mem_ready_o);
        end
        idle_cycles(RL + 4);
        do_txn($urandom, $urandom, 4'b0000, 64'h0, 0, 1'b0, 32'h0, rc);
        check_ready_cyc("after_reset_mid", rc, RL + 2);
        idle_cycles(2);
    endtask

    task automatic test_random_txn();
        int rc, ab;
        logic [63:0] mask;
        for (int i = 0; i < 25; i++) begin
            mask = 64'(($urandom & $urandom) & 32'h001F_FFFE);
            ab   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, RL + 1)) : 0;
            do_txn($urandom, $urandom, 4'($urandom), mask, ab, 1'b0, 32'h0, rc);
            if (ab > 0) check_ready_cyc("random_abort", rc, -1);
            if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 2));
        end
        idle_cycles(2);
    endtask

    task automatic test_irq_directed();
        int hits;
        irq_clear();
        hits = 0;
        for (int i = 0; i < 10; i++) begin
            irq_step(4'b0101, 1'b0);
            tests++;
            if (irq_o !== ((i == 3) ? 4'b0101 : 4'b0000)) begin
                fails++;
                $display("FAIL irq_0101 step=%0d got=%b exp=%b", i, irq_o, (i == 3) ? 4'b0101 : 4'b0000);
            end
        end
        for (int i = 0; i < 6; i++) irq_step(4'b0000, 1'b0);
        for (int i = 0; i < 6; i++) begin
            irq_step(4'b0010, 1'b0);
            tests++;
            if (irq_o !== ((i == 3) ? 4'b0010 : 4'b0000)) begin
                fails++;
                $display("FAIL irq_ch1 step=%0d got=%b exp=%b", i, irq_o, (i == 3) ? 4'b0010 : 4'b0000);
            end
        end
        for (int i = 0; i < 6; i++) irq_step(4'b0000, 1'b0);
    endtask

    task automatic test_irq_random();
        irq_clear();
        for (int i = 0; i < 80; i++) irq_step(NIRQ'($urandom), 1'($urandom));
        for (int i = 0; i < 6; i++) irq_step('0, 1'b0);
    endtask

    initial begin
        reset_i     = 1'b1;
        mem_valid_i = 1'b0;
        mem_addr_i  = '0;
        mem_wdata_i = '0;
        mem_wstrb_i = '0;
        cpu_halt_i  = 1'b0;
        data_i      = '0;
        irq_i       = '0;
        test_reset();
        test_read_basic();
        test_write();
        test_halt_wait();
        test_halt_resp();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_random_txn();
        test_irq_directed();
        test_irq_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout tests=%0d", tests);
        $fatal(1, "watchdog");
    end

endmodule
